calib_seq: RTL
==============

Name: calib_seq

Overview:
- Calibration initiator. Issues programmable trains of FINJ/FPLS strobes into the calibration trigger logic.
- Watches the returning CAL_GTRG and measures the injection-to-L1A latency of each strobe.
- Flags missing responses (timeout) and unexpected responses (extra).
- Sits in the JTAG/CSR domain on CLKCMS. Lets software scan CALGDLY/XL1ADLY settings without host-timed pulses.

Parameters:
TMR, 0, 1 = triplicate FSM state and counters via the team's voted-register scheme
CNT_W, 16, width of pulse count and response count
LAT_W, 12, width of latency and timeout counters

Ports:
CLKCMS  in  1  system clock
RST  in  1  asynchronous active-high reset
START  in  1  level, sampled only in IDLE; starts a train
ABORT  in  1  returns FSM to IDLE from any state
MODE  in  1  0 = drive FINJ, 1 = drive FPLS
NPULSE  in  CNT_W  strobes per train
WIDTH  in  3  strobe width minus 1, in clocks
GAP  in  16  idle clocks after each response or timeout
TIMEOUT  in  LAT_W  maximum wait for CAL_GTRG, in clocks
CAL_GTRG  in  1  calibration L1A returned from the trigger logic, CLKCMS-synchronous
FINJ  out  1  injection strobe, registered
FPLS  out  1  external pulse strobe, registered
BUSY  out  1  high in any state other than IDLE
DONE  out  1  one-cycle pulse at normal train completion
PCNT  out  CNT_W  strobes issued in the current or last train
RCNT  out  CNT_W  responses received
LAT  out  LAT_W  latency of the most recent response
ERR_TO  out  1  sticky: at least one timeout occurred
ERR_EXTRA  out  1  sticky: CAL_GTRG edge seen outside WAIT_RSP

Behaviour:
- Reset (async): state IDLE. All outputs 0; all counters 0.
- Edge detect: gedge = CAL_GTRG & ~gtrg_q, where gtrg_q is CAL_GTRG registered once.
- IDLE:
  - START=1 and NPULSE!=0: latch MODE/NPULSE/WIDTH/GAP/TIMEOUT; clear PCNT, RCNT, ERR_TO, ERR_EXTRA, LAT; next FIRE.
  - START=1 and NPULSE==0: DONE=1 on the next cycle; stay IDLE; no strobe.
- FIRE:
  - Selected strobe (FINJ or FPLS, never both) is high for exactly WIDTH+1 cycles. The first high cycle is the cycle after START is sampled.
  - PCNT increments once on FIRE entry.
  - Latency counter lat = 0 in the first FIRE cycle and increments every cycle after.
  - Leaving FIRE goes to WAIT_RSP.
- WAIT_RSP:
  - gedge: LAT <= lat value of that cycle, so LAT=k when the strobe rises at cycle 0 and CAL_GTRG first goes high at cycle k. RCNT++. Next GAP.
  - lat == TIMEOUT with no gedge: ERR_TO <= 1; next GAP.
  - gedge and timeout in the same cycle: the response wins (LAT captured, no ERR_TO).
  - lat saturates at all-ones and never wraps. TIMEOUT=0 means timeout in the first WAIT_RSP cycle unless gedge occurs in that cycle.
- GAP:
  - Dwell GAP cycles. GAP=0 skips the dwell and decides in a single cycle.
  - Then: PCNT==NPULSE latched → DONE state; otherwise → FIRE.
- DONE state: DONE=1 for one cycle; next IDLE.
- gedge in FIRE, GAP, DONE or IDLE while BUSY: ERR_EXTRA <= 1. The response is not counted and LAT is unchanged.
- ABORT:
  - Has priority over all transitions. Next state IDLE, FINJ=FPLS=0 next cycle, DONE not asserted.
  - PCNT, RCNT, LAT and error flags hold their values.
- START held high through completion restarts a new train on the cycle after DONE. Counters are cleared at that restart.
- Config inputs are ignored while BUSY.
- Counters PCNT and RCNT cannot exceed NPULSE, so no wrap case exists.

Decomposition:
- Package calib_seq_pkg:
  - State encoding: IDLE, FIRE, WAIT_RSP, GAP, DONE (one-hot for TMR).
  - MODE_INJ = 0, MODE_PLS = 1.
  - Default CNT_W and LAT_W.
- One sub-module, calib_seq_tmr: loadable down-counter with a zero flag. It is shared for the WIDTH and GAP dwells and is TMR-aware.

Test Plan:
1. MODE=0, NPULSE=3, WIDTH=1, GAP=10, TIMEOUT=400, response model returns CAL_GTRG 130 cycles after each FINJ rise → three 2-cycle FINJ pulses, FPLS=0, LAT=130, RCNT=3, PCNT=3, one DONE pulse, ERR_TO=ERR_EXTRA=0.
2. MODE=1, NPULSE=2, TIMEOUT=50, no response → FPLS pulses twice, ERR_TO=1 after the first wait (51st cycle after strobe rise), RCNT=0, DONE asserted.
3. START with NPULSE=0 → DONE high exactly one cycle later, BUSY stays 0, no strobe.
4. ABORT during WAIT_RSP of pulse 2 of 5 → IDLE next cycle, BUSY=0, no DONE, PCNT=2 retained.
5. Response model emits a second CAL_GTRG edge during GAP → ERR_EXTRA=1 sticky, RCNT unaffected. A new START clears ERR_EXTRA.
6. Assert RST during the FINJ high phase → FINJ=0 and all outputs 0 in the same cycle (async); after release, START runs a clean train.

Source files
------------

// File: rtl/calib_seq_pkg.sv
// calib_seq_pkg: shared types and constants for the calibration sequencer.
// State encoding is one-hot so the triplicated copies can be bitwise voted.
package calib_seq_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int LAT_W_DEF = 12;
    localparam int GAP_W     = 16;
    localparam int WID_W     = 3;

    localparam logic MODE_INJ = 1'b0;
    localparam logic MODE_PLS = 1'b1;

    typedef enum logic [4:0] {
        S_IDLE = 5'b00001,
        S_FIRE = 5'b00010,
        S_WAIT = 5'b00100,
        S_GAP  = 5'b01000,
        S_DONE = 5'b10000
    } state_t;

    // Bitwise 2-of-3 majority over one-hot state copies
    function automatic logic [4:0] vote3(
        input logic [4:0] a,
        input logic [4:0] b,
        input logic [4:0] c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/calib_seq_tmr.sv
// calib_seq_tmr: loadable down-counter with zero flag, optionally triplicated.
// Used for both the strobe-width and the inter-pulse gap dwell.
module calib_seq_tmr
    import calib_seq_pkg::*;
#(
    parameter int W   = GAP_W,
    parameter int TMR = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    localparam int NR = (TMR != 0) ? 3 : 1;

    logic [W-1:0] cnt_q [NR];
    logic [W-1:0] cur;
    logic [W-1:0] nxt;

    generate
        if (TMR != 0) begin : g_vote
            assign cur = (cnt_q[0] & cnt_q[1])
                       | (cnt_q[0] & cnt_q[2])
                       | (cnt_q[1] & cnt_q[2]);
        end else begin : g_plain
            assign cur = cnt_q[0];
        end
    endgenerate

    assign zero = (cur == '0);

    // Next count: load wins, otherwise count down and stop at zero
    always_comb begin
        nxt = cur;
        if (load) begin
            nxt = load_val;
        end else if (dec && !zero) begin
            nxt = cur - 1'b1;
        end
    end

    // Every copy takes the voted next value, so a single upset heals itself
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NR; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NR; i++) begin
                cnt_q[i] <= nxt;
            end
        end
    end

endmodule

// File: rtl/calib_seq.sv
// calib_seq: issues FINJ/FPLS strobe trains and measures the latency of
// each returning CAL_GTRG, flagging timeouts and unexpected responses.
module calib_seq
    import calib_seq_pkg::*;
#(
    parameter int TMR   = 0,
    parameter int CNT_W = CNT_W_DEF,
    parameter int LAT_W = LAT_W_DEF
) (
    input  logic             CLKCMS,
    input  logic             RST,
    input  logic             START,
    input  logic             ABORT,
    input  logic             MODE,
    input  logic [CNT_W-1:0] NPULSE,
    input  logic [WID_W-1:0] WIDTH,
    input  logic [GAP_W-1:0] GAP,
    input  logic [LAT_W-1:0] TIMEOUT,
    input  logic             CAL_GTRG,
    output logic             FINJ,
    output logic             FPLS,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] PCNT,
    output logic [CNT_W-1:0] RCNT,
    output logic [LAT_W-1:0] LAT,
    output logic             ERR_TO,
    output logic             ERR_EXTRA
);

    localparam int NR = (TMR != 0) ? 3 : 1;

    state_t             st_q [NR];
    state_t             state;

    logic               gtrg_q;
    logic               gedge;
    logic               finj_q;
    logic               fpls_q;
    logic               done_q;
    logic [CNT_W-1:0]   pcnt_q;
    logic [CNT_W-1:0]   rcnt_q;
    logic [LAT_W-1:0]   lat_q;
    logic [LAT_W-1:0]   lat_cnt;
    logic               err_to_q;
    logic               err_extra_q;

    logic               mode_q;
    logic [CNT_W-1:0]   npulse_q;
    logic [WID_W-1:0]   width_q;
    logic [GAP_W-1:0]   gap_q;
    logic [LAT_W-1:0]   timeout_q;

    logic               cnt_load;
    logic [GAP_W-1:0]   cnt_val;
    logic               cnt_dec;
    logic               cnt_zero;
    logic               resp_end;

    generate
        if (TMR != 0) begin : g_vote
            assign state = state_t'(vote3(st_q[0], st_q[1], st_q[2]));
        end else begin : g_plain
            assign state = st_q[0];
        end
    endgenerate

    assign gedge    = CAL_GTRG & ~gtrg_q;
    assign resp_end = gedge || (lat_cnt >= timeout_q);

    assign FINJ      = finj_q;
    assign FPLS      = fpls_q;
    assign BUSY      = (state != S_IDLE);
    assign DONE      = done_q;
    assign PCNT      = pcnt_q;
    assign RCNT      = rcnt_q;
    assign LAT       = lat_q;
    assign ERR_TO    = err_to_q;
    assign ERR_EXTRA = err_extra_q;

    // Dwell counter control: load width on strobe start, gap after a wait
    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = GAP_W'(WIDTH);
        cnt_dec  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_load = START && (NPULSE != '0);
            end
            S_FIRE: begin
                cnt_dec = 1'b1;
            end
            S_WAIT: begin
                cnt_load = resp_end;
                cnt_val  = gap_q;
            end
            S_GAP: begin
                cnt_dec  = 1'b1;
                cnt_load = cnt_zero && (pcnt_q != npulse_q);
                cnt_val  = GAP_W'(width_q);
            end
            default: begin
                cnt_load = 1'b0;
            end
        endcase
    end

    calib_seq_tmr #(
        .W   (GAP_W),
        .TMR (TMR)
    ) u_dwell (
        .clk      (CLKCMS),
        .rst      (RST),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Sequencer: state, strobes, latency counter, counts and error flags
    always_ff @(posedge CLKCMS or posedge RST) begin
        if (RST) begin
            st_q        <= '{default: S_IDLE};
            gtrg_q      <= 1'b0;
            finj_q      <= 1'b0;
            fpls_q      <= 1'b0;
            done_q      <= 1'b0;
            pcnt_q      <= '0;
            rcnt_q      <= '0;
            lat_q       <= '0;
            lat_cnt     <= '0;
            err_to_q    <= 1'b0;
            err_extra_q <= 1'b0;
            mode_q      <= MODE_INJ;
            npulse_q    <= '0;
            width_q     <= '0;
            gap_q       <= '0;
            timeout_q   <= '0;
        end else begin
            gtrg_q <= CAL_GTRG;
            done_q <= 1'b0;
            if (lat_cnt != '1) begin
                lat_cnt <= lat_cnt + 1'b1;
            end
            if (gedge && state != S_IDLE && state != S_WAIT) begin
                err_extra_q <= 1'b1;
            end
            if (ABORT) begin
                st_q   <= '{default: S_IDLE};
                finj_q <= 1'b0;
                fpls_q <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (START && NPULSE != '0) begin
                            mode_q      <= MODE;
                            npulse_q    <= NPULSE;
                            width_q     <= WIDTH;
                            gap_q       <= GAP;
                            timeout_q   <= TIMEOUT;
                            pcnt_q      <= CNT_W'(1);
                            rcnt_q      <= '0;
                            lat_q       <= '0;
                            lat_cnt     <= '0;
                            err_to_q    <= 1'b0;
                            err_extra_q <= 1'b0;
                            finj_q      <= (MODE == MODE_INJ);
                            fpls_q      <= (MODE == MODE_PLS);
                            st_q        <= '{default: S_FIRE};
                        end else if (START) begin
                            done_q <= 1'b1;
                        end
                    end
                    S_FIRE: begin
                        if (cnt_zero) begin
                            finj_q <= 1'b0;
                            fpls_q <= 1'b0;
                            st_q   <= '{default: S_WAIT};
                        end
                    end
                    S_WAIT: begin
                        if (gedge) begin
                            lat_q  <= lat_cnt;
                            rcnt_q <= rcnt_q + 1'b1;
                            st_q   <= '{default: S_GAP};
                        end else if (resp_end) begin
                            err_to_q <= 1'b1;
                            st_q     <= '{default: S_GAP};
                        end
                    end
                    S_GAP: begin
                        if (cnt_zero && pcnt_q == npulse_q) begin
                            done_q <= 1'b1;
                            st_q   <= '{default: S_DONE};
                        end else if (cnt_zero) begin
                            pcnt_q  <= pcnt_q + 1'b1;
                            lat_cnt <= '0;
                            finj_q  <= (mode_q == MODE_INJ);
                            fpls_q  <= (mode_q == MODE_PLS);
                            st_q    <= '{default: S_FIRE};
                        end
                    end
                    S_DONE: begin
                        st_q <= '{default: S_IDLE};
                    end
                    default: begin
                        finj_q <= 1'b0;
                        fpls_q <= 1'b0;
                        st_q   <= '{default: S_IDLE};
                    end
                endcase
            end
        end
    end

endmodule
